// File: rtl/fp_mul_round_pack.sv
// Normalize, round-to-nearest-even and pack an FP multiply product as IEEE single or half.
// Two register stages (latency 2, 1/cycle); in_ready falls only when both stages hold data and out_ready is low.
module fp_mul_round_pack #(
  parameter int MAX_EXP_SP = 254,
  parameter int MAX_EXP_HP = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:0] in_mant,
  input  logic [8:0]  in_exp,
  input  logic        in_sign,
  input  logic [4:0]  in_flags,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_flags
);

  localparam logic [9:0] MAX_SP10 = 10'(MAX_EXP_SP);
  localparam logic [9:0] MAX_HP10 = 10'(MAX_EXP_HP);

  logic        s2_adv, s1_adv;
  logic        s1_valid;
  logic [46:0] s1_n;
  logic [9:0]  s1_e;
  logic        s1_sign, s1_mode, s1_zero;
  logic [4:0]  s1_flags;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // The leading one is implicit after normalization, so only the fraction bits below it are kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_n     <= '0;
      s1_e     <= '0;
      s1_sign  <= 1'b0;
      s1_mode  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_flags <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_n     <= in_mant[47] ? in_mant[46:0] : {in_mant[45:0], 1'b0};
        s1_e     <= in_mant[47] ? ({1'b0, in_exp} + 10'd1) : {1'b0, in_exp};
        s1_sign  <= in_sign;
        s1_mode  <= in_mode;
        s1_zero  <= (in_mant == '0);
        s1_flags <= in_flags;
      end
    end
  end

  logic [22:0] frac_t, frac_fin;
  logic [23:0] frac_sum;
  logic        guard, sticky, round_up, carry;
  logic [9:0]  e_rnd, max_e;
  logic [31:0] inf_v, nan_v, zero_v, res_d;
  logic [4:0]  flg_d;

  always_comb begin
    if (s1_mode) begin
      frac_t = s1_n[46:24];
      guard  = s1_n[23];
      sticky = |s1_n[22:0];
    end else begin
      frac_t = {13'b0, s1_n[46:37]};
      guard  = s1_n[36];
      sticky = |s1_n[35:0];
    end
    round_up = guard && (sticky || frac_t[0]);
    frac_sum = {1'b0, frac_t} + {23'b0, round_up};
    // A round-up that wraps the fraction lands exactly on the next power of two.
    carry    = s1_mode ? frac_sum[23] : frac_sum[10];
    frac_fin = carry ? '0 : frac_sum[22:0];
    e_rnd    = s1_e + {9'b0, carry};
    max_e    = s1_mode ? MAX_SP10 : MAX_HP10;

    inf_v  = s1_mode ? {s1_sign, 8'hFF, 23'h0} : {16'h0, s1_sign, 5'h1F, 10'h0};
    nan_v  = s1_mode ? 32'h7FC0_0000 : 32'h0000_7E00;
    zero_v = s1_mode ? {s1_sign, 31'h0} : {16'h0, s1_sign, 15'h0};

    res_d = s1_mode ? {s1_sign, e_rnd[7:0], frac_fin}
                    : {16'h0, s1_sign, e_rnd[4:0], frac_fin[9:0]};
    flg_d = {4'b0, guard | sticky};

    case (s1_flags)
      5'b00000: begin
        if (s1_zero) begin
          res_d = zero_v;
          flg_d = 5'b00000;
        end else if (e_rnd > max_e) begin
          res_d = inf_v;
          flg_d = 5'b01101;
        end
      end
      5'b10000, 5'b00011: begin
        res_d = zero_v;
        flg_d = 5'b00011;
      end
      5'b11111: begin
        res_d = inf_v;
        flg_d = 5'b01000;
      end
      5'b11000: begin
        res_d = inf_v;
        flg_d = 5'b01101;
      end
      default: begin
        res_d = nan_v;
        flg_d = 5'b10000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res_d;
        out_flags  <= flg_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Randomized and directed checks of fp_mul_round_pack against an arithmetic rounding model and a result scoreboard.
module tb_fp_mul_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [48:0] in_mant;
  logic [8:0]  in_exp;
  logic        in_sign, in_mode;
  logic [4:0]  in_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  fp_mul_round_pack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .in_flags(in_flags), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_sent  = 0;
  int   n_recv  = 0;
  bit   saw_stall;

  // out_ready source: 0 = held at rdy_force, 1 = 1,0,0,1 pattern, 2 = random
  int         rdy_mode = 0;
  logic       rdy_force = 1'b1;
  logic       rdy_bit = 1'b1;
  logic [3:0] pat = 4'b1001;
  int         bp_i = 0;
  assign out_ready = (rdy_mode == 0) ? rdy_force : rdy_bit;

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1) begin
      rdy_bit = pat[bp_i];
      bp_i = (bp_i + 1) % 4;
    end else if (rdy_mode == 2) begin
      rdy_bit = ($urandom % 4) != 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Rounding expressed as integer division: keep the top significand bits, compare the dropped remainder to one half.
  function automatic void ref_model(input logic [48:0] m, input logic [8:0] ex, input logic s,
                                    input logic [4:0] fl, input logic md,
                                    output logic [31:0] r, output logic [4:0] f);
    int fb, drop, e, emax;
    longint unsigned mm, q, rem, half;
    logic [31:0] inf_v, zero_v;
    fb     = md ? 23 : 10;
    emax   = md ? 254 : 30;
    inf_v  = md ? {s, 8'hFF, 23'h0} : {16'h0, s, 5'h1F, 10'h0};
    zero_v = md ? {s, 31'h0} : {16'h0, s, 15'h0};
    if (fl == 5'b00001) begin
      r = md ? 32'h7FC0_0000 : 32'h0000_7E00;
      f = 5'b10000;
    end else if (fl == 5'b11111) begin
      r = inf_v;
      f = 5'b01000;
    end else if (fl == 5'b11000) begin
      r = inf_v;
      f = 5'b01101;
    end else if (fl == 5'b10000 || fl == 5'b00011) begin
      r = zero_v;
      f = 5'b00011;
    end else if (m == 0) begin
      r = zero_v;
      f = 5'b00000;
    end else begin
      mm = m;
      e  = int'(ex);
      if (m[47]) begin
        drop = 47 - fb;
        e = e + 1;
      end else begin
        drop = 46 - fb;
      end
      q    = mm >> drop;
      rem  = mm - (q << drop);
      half = 64'd1 << (drop - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << (fb + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e > emax) begin
        r = inf_v;
        f = 5'b01101;
      end else begin
        r = md ? {s, e[7:0], q[22:0]} : {16'h0, s, e[4:0], q[9:0]};
        f = {4'b0, rem != 0};
      end
    end
  endfunction

  // Called just after a rising edge; returns just after the edge on which the product was accepted.
  task automatic send(input logic [48:0] m, input logic [8:0] ex, input logic s, input logic [4:0] fl,
                      input logic md, input logic [31:0] er, input logic [4:0] ef);
    exp_t x;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = ex;
    in_sign  = s;
    in_flags = fl;
    in_mode  = md;
    x.r = er;
    x.f = ef;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      saw_stall = 1'b1;
    end
    if (!ok) check("send_timeout", 64'd1, 64'd0);
    else begin
      exp_q.push_back(x);
      n_sent++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic md);
    logic [23:0] a, b;
    logic [47:0] p;
    logic [48:0] m;
    logic [8:0]  ex;
    logic [4:0]  fl;
    logic        s;
    logic [31:0] er;
    logic [4:0]  ef;
    int sel;
    a = {1'b1, 23'($urandom)};
    b = {1'b1, 23'($urandom)};
    if (!md && ($urandom % 2 == 0)) begin
      a[12:0] = '0;
      b[12:0] = '0;
    end
    p  = a * b;
    m  = {1'b0, p};
    ex = md ? 9'($urandom_range(100, 300)) : 9'($urandom_range(0, 40));
    s  = 1'($urandom);
    sel = $urandom_range(0, 15);
    fl = 5'b00000;
    case (sel)
      0: fl = 5'b00001;
      1: fl = 5'b11111;
      2: fl = 5'b11000;
      3: fl = 5'b10000;
      4: fl = 5'b00011;
      5: m  = '0;
      default: ;
    endcase
    ref_model(m, ex, s, fl, md, er, ef);
    send(m, ex, s, fl, md, er, ef);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
    check({tag, "_count"}, 64'(n_recv), 64'(n_sent));
  endtask

  logic        stall_prev = 1'b0;
  logic [37:0] prev_out;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_stable", 64'({out_valid, out_flags, out_result}), 64'(prev_out));
      stall_prev = out_valid && !out_ready;
      prev_out   = {out_valid, out_flags, out_result};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 64'(out_result), 64'hDEAD_BEEF_0000);
        end else begin
          mon_x = exp_q.pop_front();
          check("result", 64'(out_result), 64'(mon_x.r));
          check("flags", 64'(out_flags), 64'(mon_x.f));
          n_recv++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d results pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_mant = '0;
    in_exp = '0;
    in_sign = 1'b0;
    in_flags = '0;
    in_mode = 1'b0;
    saw_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: single 1.5*1.5 presented now must be visible after the second rising edge.
    in_valid = 1'b1;
    in_mant  = 49'h0_9000_0000_0000;
    in_exp   = 9'd127;
    in_sign  = 1'b0;
    in_flags = 5'b00000;
    in_mode  = 1'b1;
    mon_x.r  = 32'h4010_0000;
    mon_x.f  = 5'b00000;
    exp_q.push_back(mon_x);
    n_sent++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);

    send(49'h0_9000_0000_0000, 9'd15,  1'b0, 5'b00000, 1'b0, 32'h0000_4080, 5'b00000);
    send(49'h0_4000_0040_0000, 9'd127, 1'b0, 5'b00000, 1'b1, 32'h3F80_0000, 5'b00001);
    send(49'h0_4000_00C0_0000, 9'd127, 1'b0, 5'b00000, 1'b1, 32'h3F80_0002, 5'b00001);
    send(49'h0_8000_0000_0000, 9'd254, 1'b0, 5'b00000, 1'b1, 32'h7F80_0000, 5'b01101);
    send(49'h0_8000_0000_0000, 9'd254, 1'b0, 5'b00001, 1'b1, 32'h7FC0_0000, 5'b10000);
    send(49'h0_8000_0000_0000, 9'd254, 1'b1, 5'b00011, 1'b1, 32'h8000_0000, 5'b00011);
    send(49'h0_0000_0000_0000, 9'd10,  1'b1, 5'b00000, 1'b0, 32'h0000_8000, 5'b00000);
    send(49'h0_9000_0000_0000, 9'd20,  1'b0, 5'b11111, 1'b0, 32'h0000_7C00, 5'b01000);
    send(49'h0_7FFF_FF80_0000, 9'd30,  1'b1, 5'b00000, 1'b0, 32'h0000_FC00, 5'b01101);
    drain("directed_drain");

    rdy_mode = 1;
    saw_stall = 1'b0;
    for (int i = 0; i < 8; i++) send_rand(1'b1);
    drain("bp_drain");
    check("bp_in_ready_dropped", 64'(saw_stall), 64'd1);
    rdy_mode = 0;

    // Fill both stages with the sink stalled, then reset asynchronously.
    rdy_force = 1'b0;
    send(49'h0_9000_0000_0000, 9'd127, 1'b0, 5'b00000, 1'b1, 32'h4010_0000, 5'b00000);
    send(49'h0_9000_0000_0000, 9'd15,  1'b0, 5'b00000, 1'b0, 32'h0000_4080, 5'b00000);
    check("full_in_ready", 64'(in_ready), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    n_sent -= 2;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_force = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 64'(out_valid), 64'd0);
    send(49'h0_4000_00C0_0000, 9'd127, 1'b1, 5'b00000, 1'b1, 32'hBF80_0002, 5'b00001);
    check("post_rst_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("post_rst_cycle2", 64'(out_valid), 64'd1);
    drain("post_rst_drain");

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      send_rand(1'($urandom));
      if ($urandom % 6 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain("random_drain");
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
